// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Truth-code width for an n-input gate.
  function automatic int unsigned code_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Counter width able to hold 0 .. max(settle, samples)-1.
  function automatic int unsigned cnt_width(input int unsigned settle, input int unsigned samples);
    int unsigned m;
    m = (settle > samples) ? settle : samples;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tt_majority_sampler.sv
// Majority voter over SAMPLES consecutive enabled cycles. vote is valid in the
// cycle where last is high and already includes that cycle's bit_in.
module tt_majority_sampler #(
  parameter int unsigned SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic last,
  input  logic flush,
  input  logic bit_in,
  output logic vote
);

  localparam int unsigned OW = $clog2(SAMPLES + 1);

  logic [OW-1:0] ones;
  logic [OW:0]   total;

  // Ones seen so far plus the bit being presented now.
  always_comb begin
    total = {1'b0, ones} + (OW + 1)'(bit_in);
    vote  = (total > (OW + 1)'(SAMPLES / 2));
  end

  // Accumulate ones across the window; clear at window end or on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= '0;
    end else if (flush) begin
      ones <= '0;
    end else if (en) begin
      ones <= last ? '0 : ones + OW'(bit_in);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input combination of an N_IN-input gate,
// waits SETTLE_CYCLES, samples its output and assembles the truth code
// (row 0 in the MSB). Build option TT_MAJORITY_VOTE_EN samples each row
// SAMPLES times and keeps the majority value.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic [N_IN-1:0]               stim,
  input  logic                          dut_out,
  output logic                          busy,
  output logic                          done,
  output logic [code_width(N_IN)-1:0]   truth_code
);

  localparam int unsigned CW = code_width(N_IN);
  localparam int unsigned KW = cnt_width(SETTLE_CYCLES, SAMPLES);

  state_t          state, state_n;
  logic [N_IN-1:0] row, row_n, stim_n, bit_idx;
  logic [KW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   shadow, shadow_n, code_n;
  logic            busy_n, done_n;
  logic            sample_bit, sample_last;

  // Row r lands in bit CW-1-r, which for an N_IN-bit row is simply ~r.
  assign bit_idx = ~row;

`ifdef TT_MAJORITY_VOTE_EN
  assign sample_last = (cnt == KW'(SAMPLES - 1));

  tt_majority_sampler #(
    .SAMPLES (SAMPLES)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .en     (state == SAMPLE),
    .last   (sample_last),
    .flush  (abort && (state == SAMPLE)),
    .bit_in (dut_out),
    .vote   (sample_bit)
  );
`else
  assign sample_last = 1'b1;
  assign sample_bit  = dut_out;
`endif

  // Next-state and next-output logic; abort returns to IDLE without a result.
  always_comb begin
    state_n  = state;
    row_n    = row;
    cnt_n    = cnt;
    stim_n   = stim;
    busy_n   = busy;
    done_n   = 1'b0;
    shadow_n = shadow;
    code_n   = truth_code;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SETTLE;
          row_n    = '0;
          stim_n   = '0;
          cnt_n    = '0;
          shadow_n = '0;
          busy_n   = 1'b1;
        end
      end
      SETTLE, SAMPLE: begin
        if (abort) begin
          state_n  = IDLE;
          row_n    = '0;
          stim_n   = '0;
          cnt_n    = '0;
          shadow_n = '0;
          busy_n   = 1'b0;
        end else if (state == SETTLE) begin
          if (cnt == KW'(SETTLE_CYCLES - 1)) begin
            state_n = SAMPLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + KW'(1);
          end
        end else if (!sample_last) begin
          cnt_n = cnt + KW'(1);
        end else begin
          shadow_n[bit_idx] = sample_bit;
          cnt_n             = '0;
          if (row == '1) begin
            // Outputs are registered, so the DONE cycle already shows the result.
            state_n = DONE;
            code_n  = shadow_n;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            stim_n  = '0;
            row_n   = '0;
          end else begin
            state_n = SETTLE;
            row_n   = row + N_IN'(1);
            stim_n  = row + N_IN'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      cnt        <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shadow     <= '0;
      truth_code <= '0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      cnt        <= cnt_n;
      stim       <= stim_n;
      busy       <= busy_n;
      done       <= done_n;
      shadow     <= shadow_n;
      truth_code <= code_n;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper (3-input gate model with a
// 2-cycle output delay).
module tb_truth_table_sweeper;

  localparam int S   = 4;
  localparam int SMP = 3;
`ifdef TT_MAJORITY_VOTE_EN
  localparam int ROW_LEN = S + SMP;
`else
  localparam int ROW_LEN = S + 1;
`endif
  localparam int SWEEP_LEN = 8 * ROW_LEN;

  logic       clk = 1'b0;
  logic       rst, start, abort, dut_out;
  logic [2:0] stim;
  logic       busy, done;
  logic [7:0] truth_code;

  int         gate_mode;
  logic [7:0] gate_code;
  logic       d1, d2, glitch;

  int         errors = 0;
  int         checks = 0;
  int         glitch_at = -1;
  bit         spam = 1'b0;
  logic [7:0] last_code = 8'h00;

  truth_table_sweeper #(
    .N_IN          (3),
    .SETTLE_CYCLES (S),
    .SAMPLES       (SMP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .stim       (stim),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .truth_code (truth_code)
  );

  always #5 clk = ~clk;

  // Gate behaviour: 0 = table lookup, 1 = in3, 2 = const 0, 3 = in1, 4 = parity.
  function automatic logic gate_fn(input int mode, input logic [7:0] code, input logic [2:0] s);
    case (mode)
      0:       return code[~s];
      1:       return s[0];
      2:       return 1'b0;
      3:       return s[2];
      4:       return ^s;
      default: return 1'b0;
    endcase
  endfunction

  // Expected code: evaluate the gate on every row, row 0 into the MSB.
  function automatic logic [7:0] ref_code(input int mode, input logic [7:0] code);
    logic [7:0] c;
    c = 8'h00;
    for (int r = 0; r < 8; r++) begin
      if (gate_fn(mode, code, 3'(r))) c = c | (8'h80 >> r);
    end
    return c;
  endfunction

  always @(posedge clk) begin
    d1 <= gate_fn(gate_mode, gate_code, stim);
    d2 <= d1;
  end
  assign dut_out = d2 ^ glitch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic sweep(input string name, input logic [7:0] exp);
    int n;
    int unstable;
    bit seen;
    kick();
    @(negedge clk);
    check({name, "_busy_on"}, busy, 1);
    n = 0; seen = 1'b0; unstable = 0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      n++;
      #1 glitch = (n == glitch_at);
      if (spam) start = (n < 35) && n[0];
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (truth_code !== last_code) unstable++;
    end
    glitch = 1'b0;
    start  = 1'b0;
    check({name, "_latency"}, n, SWEEP_LEN);
    check({name, "_code"}, truth_code, exp);
    check({name, "_busy_off"}, busy, 0);
    check({name, "_stim_zero"}, stim, 0);
    check({name, "_code_stable"}, unstable, 0);
    last_code = exp;
  endtask

  task automatic wait_stim(input logic [2:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (stim == v) ok = 1'b1;
    end
  endtask

  task automatic watch(input int cycles, output int dones, output int busys);
    dones = 0; busys = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busys++;
    end
  endtask

  typedef struct {
    int         mode;
    logic [7:0] code;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[5];
    bit   ok;
    int   nd, nb;
    logic [7:0] e;

    tbl[0] = '{0, 8'hB7, 8'hB7};
    tbl[1] = '{1, 8'h00, 8'h55};
    tbl[2] = '{2, 8'h00, 8'h00};
    tbl[3] = '{3, 8'h00, 8'h0F};
    tbl[4] = '{4, 8'h00, 8'h69};

    rst = 1'b1; start = 1'b0; abort = 1'b0; glitch = 1'b0;
    gate_mode = 0; gate_code = 8'hB7;
    repeat (3) @(negedge clk);
    check("reset_stim", stim, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_code", truth_code, 0);
    rst = 1'b0;

    // Back-to-back table sweeps: each start lands in the IDLE cycle after done.
    for (int i = 0; i < 5; i++) begin
      gate_mode = tbl[i].mode;
      gate_code = tbl[i].code;
      sweep($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // start during the DONE cycle is ignored.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("done_start_busy", busy, 0);
    check("done_pulse_width", done, 0);
    @(negedge clk);
    check("done_start_busy2", busy, 0);

    // Randomized gates against the row-by-row reference.
    for (int i = 0; i < 6; i++) begin
      gate_mode = $urandom_range(4);
      gate_code = 8'($urandom);
      e = ref_code(gate_mode, gate_code);
      sweep($sformatf("rnd%0d", i), e);
    end

    // Abort at row 5 keeps the earlier result.
    gate_mode = 0; gate_code = 8'hB7;
    sweep("pre_abort", 8'hB7);
    gate_code = 8'h12;
    kick();
    wait_stim(3'd5, ok);
    check("abort_reach_row5", ok, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_stim", stim, 0);
    check("abort_code", truth_code, 8'hB7);
    watch(60, nd, nb);
    check("abort_no_done", nd, 0);
    check("abort_code_kept", truth_code, 8'hB7);

    // Repeated start during a sweep: no restart, normal completion.
    gate_code = 8'h3C;
    spam = 1'b1;
    sweep("spam", 8'h3C);
    spam = 1'b0;

    // start and abort together in SETTLE: abort wins.
    kick();
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("sa_busy", busy, 0);
    check("sa_stim", stim, 0);
    watch(50, nd, nb);
    check("sa_no_done", nd, 0);
    check("sa_no_restart", nb, 0);
    check("sa_code_kept", truth_code, 8'h3C);

    // Asynchronous reset mid-SETTLE of row 3.
    gate_code = 8'hA5;
    kick();
    wait_stim(3'd3, ok);
    check("rst_reach_row3", ok, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_stim", stim, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_code", truth_code, 0);
    @(negedge clk);
    rst = 1'b0;
    last_code = 8'h00;
    gate_code = 8'hB7;
    sweep("post_rst", 8'hB7);

`ifdef TT_MAJORITY_VOTE_EN
    // One inverted cycle inside row 1's sample window is outvoted.
    glitch_at = 12;
    sweep("vote_glitch", 8'hB7);
    glitch_at = -1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Characterisation block that reads back the truth table of an N-input, 1-output logic gate, the complement of the gate modules that realise a given table.
- Sequentially drives every input combination onto the gate under test, waits a settle window, samples the gate output, and assembles the hex truth code (e.g. 0xB7 for 3 inputs).
- Used in bench/FPGA harnesses to confirm that a synthesised gate matches its intended code.

Parameters:
- N_IN, 3, number of gate inputs; code width is 2**N_IN (legal 1..4).
- SETTLE_CYCLES, 4, clocks to wait after each stimulus change before sampling (legal >= 1).
- SAMPLES, 3, samples taken per row when the vote feature is compiled in (odd, legal 1..7); ignored otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request, sampled in IDLE only.
- abort  input  1  cancels a running sweep.
- stim  output  N_IN  drive to gate; stim[N_IN-1] is in1 (MSB), stim[0] is in_N.
- dut_out  input  1  gate output; synchronous to clk or externally synchronised.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse when a full sweep completes.
- truth_code  output  2**N_IN  last completed code; row r (stim value r) maps to bit (2**N_IN-1-r), so row 0 is the MSB.

Behaviour:
- Reset values: stim=0, busy=0, done=0, truth_code=0, FSM=IDLE, row=0, counters=0. Reset is honoured mid-sweep: the partial result is discarded and all outputs take their reset values immediately.
- FSM states and transitions:
  - IDLE: on start=1, go to SETTLE with row=0, stim=0, cnt=0, busy=1.
  - SETTLE: cnt increments each clock. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: write dut_out into the shadow bit for the current row. If row==2**N_IN-1, go to DONE. Otherwise row++, stim<=row+1, cnt=0, and return to SETTLE.
  - DONE: copy shadow to truth_code, pulse done=1 for one cycle, busy=0, stim=0, then return to IDLE.
- Timing:
  - Each row lasts exactly SETTLE_CYCLES+1 clocks.
  - Defaults give 8*5=40 clocks from the start-accept edge to the DONE cycle.
  - dut_out is sampled SETTLE_CYCLES+... precisely, on the clock edge ending the SAMPLE state, which is SETTLE_CYCLES+1 edges after stim changed.
- start while busy: ignored, with no restart and no queueing. start asserted in the DONE cycle is also ignored. start in IDLE the cycle after DONE is accepted.
- abort:
  - In SETTLE or SAMPLE, the next state is IDLE with stim=0, busy=0 and no done pulse.
  - truth_code keeps its previous completed value; only the shadow register is discarded.
  - abort in IDLE or DONE has no effect. abort takes priority over start in the same cycle.
- truth_code changes only in the DONE cycle and is stable otherwise.
- row wraps cleanly: the final row ends the sweep and never increments past 2**N_IN-1.

Optional Feature:
- Macro: TT_MAJORITY_VOTE_EN.
- Defined:
  - SAMPLE lasts SAMPLES consecutive clocks. The row bit is the majority of the SAMPLES captured values.
  - Per-row length is SETTLE_CYCLES+SAMPLES; defaults give 8*7=56 clocks.
  - abort is honoured in any of the sample cycles.
- Undefined: a single sample per row as described above; the SAMPLES parameter is unused.

Decomposition:
- Package tt_sweep_pkg:
  - FSM state enum {IDLE, SETTLE, SAMPLE, DONE}.
  - Function for the code width (2**n).
  - Function for the counter width ($clog2 of max(SETTLE_CYCLES, SAMPLES)).
- One natural sub-module, tt_majority_sampler: counts the ones over SAMPLES cycles and outputs the majority bit. It is instantiated only under TT_MAJORITY_VOTE_EN.

Test Plan:
- Bench gate model implementing 0xB7 with a 2-cycle output delay, start pulse -> done exactly 40 clocks after the accept edge, truth_code=8'hB7, stim returns to 0.
- Models out=in3 then out=0 -> truth_code=8'h55, then 8'h00, two back-to-back sweeps with start asserted the cycle after done.
- abort at row 5 after a prior 8'hB7 result -> no done pulse, busy falls, stim=0, truth_code stays 8'hB7.
- start pulsed repeatedly during a sweep, and start+abort together in SETTLE -> no restart, and the abort wins.
- rst asserted asynchronously mid-SETTLE of row 3 -> all outputs zero immediately; a fresh sweep afterwards completes normally.
- With TT_MAJORITY_VOTE_EN, SAMPLES=3, a 0xB7 model plus a single-cycle inverted glitch during row 1's sample window -> truth_code=8'hB7, 56 clocks.
